// File: rtl/fmult_accum.sv
// ---------------------------------------------------------------------------
// fmult_accum
//
// Signal-estimate block of an ADPCM (G.726-style) adaptive predictor. Each of
// the eight predictor coefficients is multiplied by its floating-point history
// sample using the FMULT algorithm. One product is formed per clock by a
// shared multiplier. The products are summed modulo 2^16 to give the
// zero-section estimate (SEZ) and the full signal estimate (SE).
//
// A computation starts on each rising edge of start_trig. The edge is seen
// after a two-flop synchroniser. Outputs update 12 clk after the rising edge
// and hold until the next update. Rising edges seen outside IDLE are ignored.
//
// Ports
//   clk                   system clock, rising edge
//   reset                 synchronous, active-low reset
//   start_trig            sample strobe (asynchronous to clk)
//   A1, A2   [15:0]       pole coefficients, two's complement
//   B1..B6   [15:0]       zero coefficients, two's complement
//   SR1, SR2 [10:0]       reconstructed signal, float {sign, exp[3:0], mant[5:0]}
//   DQ1..DQ6 [10:0]       quantized difference, same float format
//   SEZ      [14:0]       zero-section estimate, two's complement
//   SE       [14:0]       signal estimate, two's complement
//   test_mode, scan_enable, scan_in0..4   DFT inputs, no functional effect
//   scan_out0..4          scan outputs, tied low until scan insertion
// ---------------------------------------------------------------------------
module fmult_accum (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_trig,
  input  logic [15:0] A1,
  input  logic [15:0] A2,
  input  logic [15:0] B1,
  input  logic [15:0] B2,
  input  logic [15:0] B3,
  input  logic [15:0] B4,
  input  logic [15:0] B5,
  input  logic [15:0] B6,
  input  logic [10:0] SR1,
  input  logic [10:0] SR2,
  input  logic [10:0] DQ1,
  input  logic [10:0] DQ2,
  input  logic [10:0] DQ3,
  input  logic [10:0] DQ4,
  input  logic [10:0] DQ5,
  input  logic [10:0] DQ6,
  input  logic        test_mode,
  input  logic        scan_enable,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  output logic [14:0] SEZ,
  output logic [14:0] SE,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // FMULT: 16-bit two's complement coefficient times 11-bit float sample,
  // returning a 16-bit two's complement product.
  function automatic logic [15:0] fmult(input logic [15:0] c, input logic [10:0] f);
    logic        cs;
    logic [13:0] cshr;
    logic [12:0] cmag;
    logic [3:0]  cexp;
    logic [18:0] cmag_sh;
    logic [5:0]  cmant;
    logic        ws;
    logic [4:0]  wexp;
    logic [11:0] mprod;
    logic [7:0]  wmant;
    logic [14:0] wm_base;
    logic [16:0] wm_up;
    logic [14:0] wmag;

    cs   = c[15];
    cshr = c[15:2];
    // Negative coefficients: 16384 - (C>>2) truncated to 13 bits equals the
    // 14-bit two's complement negation truncated to 13 bits.
    cmag = cs ? 13'(14'd0 - cshr) : cshr[12:0];

    cexp = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (cmag[i]) cexp = 4'(i + 1);
    end

    // Normalised mantissa always lands in 32..63, so 6 bits suffice.
    cmag_sh = {cmag, 6'b0} >> cexp;
    cmant   = (cmag == 13'd0) ? 6'd32 : cmag_sh[5:0];

    ws    = f[10] ^ cs;
    wexp  = {1'b0, f[9:6]} + {1'b0, cexp};
    mprod = 12'(f[5:0]) * 12'(cmant) + 12'd48;
    wmant = mprod[11:4];

    wm_base = {wmant, 7'b0};
    if (wexp > 5'd26) begin
      wm_up = {2'b0, wm_base} << (wexp - 5'd26);
      wmag  = wm_up[14:0];
    end else begin
      wmag  = wm_base >> (5'd26 - wexp);
    end

    return ws ? (16'd0 - {1'b0, wmag}) : {1'b0, wmag};
  endfunction

  // Synchroniser [0],[1] plus edge-detect history [2].
  logic [2:0]  r_sync;
  logic        w_start;
  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_k;
  logic [15:0] r_acc;
  logic [15:0] r_sezi;
  logic [14:0] r_sez;
  logic [14:0] r_se;
  logic [15:0] r_coef [8];
  logic [10:0] r_samp [8];
  logic [15:0] w_prod;
  logic [15:0] w_acc_next;
  logic        w_unused_dft;

  assign w_start = r_sync[1] & ~r_sync[2];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync  <= 3'b000;
      r_state <= IDLE;
    end else begin
      r_sync  <= {r_sync[1:0], start_trig};
      r_state <= w_state_next;
    end
  end

  // NOTE: the next-state value is given a default before the case so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = MAC;
      MAC:     if (r_k == 3'd7) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Product order: k=0..5 -> B1*DQ1 .. B6*DQ6, k=6 -> A1*SR1, k=7 -> A2*SR2.
  // NOTE: the operand registers carry no reset; they are only read after a
  // capture has written them, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (reset && (r_state == IDLE) && w_start) begin
      r_coef[0] <= B1;  r_samp[0] <= DQ1;
      r_coef[1] <= B2;  r_samp[1] <= DQ2;
      r_coef[2] <= B3;  r_samp[2] <= DQ3;
      r_coef[3] <= B4;  r_samp[3] <= DQ4;
      r_coef[4] <= B5;  r_samp[4] <= DQ5;
      r_coef[5] <= B6;  r_samp[5] <= DQ6;
      r_coef[6] <= A1;  r_samp[6] <= SR1;
      r_coef[7] <= A2;  r_samp[7] <= SR2;
    end
  end

  assign w_prod     = fmult(r_coef[r_k], r_samp[r_k]);
  assign w_acc_next = r_acc + w_prod;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_k    <= 3'd0;
      r_acc  <= 16'd0;
      r_sezi <= 16'd0;
      r_sez  <= 15'd0;
      r_se   <= 15'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_k   <= 3'd0;
            r_acc <= 16'd0;
          end
        end
        MAC: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + 3'd1;
          // The zero section ends with the sixth product.
          if (r_k == 3'd5) r_sezi <= w_acc_next;
        end
        DONE: begin
          r_sez <= r_sezi[15:1];
          r_se  <= r_acc[15:1];
        end
        default: ;
      endcase
    end
  end

  assign SEZ = r_sez;
  assign SE  = r_se;

  // DFT pins are stitched by scan insertion; functionally they are inert.
  assign w_unused_dft = ^{test_mode, scan_enable, scan_in0, scan_in1,
                          scan_in2, scan_in3, scan_in4};
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

endmodule

// File: tb/tb_fmult_accum.sv
// ---------------------------------------------------------------------------
// tb_fmult_accum
//
// Self-checking bench for fmult_accum. A reference model computes FMULT with
// plain integer arithmetic, sums the products and derives SEZ/SE. Directed
// vectors cover reset, all-zero, pole-only, zero-only, negative and extreme
// operands. Random vectors follow, some with a spurious start_trig rise and
// operand scrambling injected mid-computation. A mid-computation reset abort
// is also exercised.
// ---------------------------------------------------------------------------
module tb_fmult_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_trig;
  logic [15:0] coef [8];
  logic [10:0] samp [8];
  logic [14:0] SEZ, SE;
  logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

  int n_checks = 0;
  int n_errors = 0;
  int prev_sez = 0;
  int prev_se  = 0;

  always #5 clk = ~clk;

  fmult_accum dut (
    .clk        (clk),
    .reset      (reset),
    .start_trig (start_trig),
    .A1         (coef[6]),
    .A2         (coef[7]),
    .B1         (coef[0]),
    .B2         (coef[1]),
    .B3         (coef[2]),
    .B4         (coef[3]),
    .B5         (coef[4]),
    .B6         (coef[5]),
    .SR1        (samp[6]),
    .SR2        (samp[7]),
    .DQ1        (samp[0]),
    .DQ2        (samp[1]),
    .DQ3        (samp[2]),
    .DQ4        (samp[3]),
    .DQ5        (samp[4]),
    .DQ6        (samp[5]),
    .test_mode  (1'b0),
    .scan_enable(1'b0),
    .scan_in0   (1'b0),
    .scan_in1   (1'b0),
    .scan_in2   (1'b0),
    .scan_in3   (1'b0),
    .scan_in4   (1'b0),
    .SEZ        (SEZ),
    .SE         (SE),
    .scan_out0  (scan_out0),
    .scan_out1  (scan_out1),
    .scan_out2  (scan_out2),
    .scan_out3  (scan_out3),
    .scan_out4  (scan_out4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FMULT straight from its arithmetic definition.
  function automatic int fmult_ref(input int c, input int f);
    int cs, cmag, cexp, cmant, ws, wexp, wmant, wmag;
    cs   = (c >> 15) & 1;
    cmag = cs ? ((16384 - (c >> 2)) & 8191) : (c >> 2);
    cexp = 0;
    while ((cmag >> cexp) != 0) cexp++;
    cmant = (cmag == 0) ? 32 : ((cmag << 6) >> cexp);
    ws    = ((f >> 10) & 1) ^ cs;
    wexp  = ((f >> 6) & 15) + cexp;
    wmant = ((f & 63) * cmant + 48) >> 4;
    if (wexp > 26) wmag = ((wmant << 7) << (wexp - 26)) & 32767;
    else           wmag = (wmant << 7) >> (26 - wexp);
    return ws ? ((65536 - wmag) & 65535) : wmag;
  endfunction

  task automatic model(output int exp_sez, output int exp_se);
    int sum;
    sum = 0;
    for (int k = 0; k < 8; k++) begin
      sum = sum + fmult_ref(int'(coef[k]), int'(samp[k]));
      if (k == 5) exp_sez = (sum & 65535) >> 1;
    end
    exp_se = (sum & 65535) >> 1;
  endtask

  task automatic clear_ops();
    for (int k = 0; k < 8; k++) begin
      coef[k] = 16'h0000;
      samp[k] = 11'h000;
    end
  endtask

  task automatic random_ops();
    for (int k = 0; k < 8; k++) begin
      coef[k] = 16'($urandom);
      samp[k] = 11'($urandom);
    end
  endtask

  // Called at a negedge with operands already set. Runs one full 34-clk
  // start_trig period (17 high, 17 low) and checks the outputs every clock.
  task automatic run_vec(input string name, input bit inject);
    int exp_sez, exp_se;
    logic ok;
    model(exp_sez, exp_se);
    start_trig = 1'b1;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      @(negedge clk);
      if (cyc < 12) begin
        ok = ((int'(SEZ) == prev_sez) || (int'(SEZ) == exp_sez)) &&
             ((int'(SE)  == prev_se)  || (int'(SE)  == exp_se));
        check({name, "_window"}, {31'd0, ok}, 32'd1);
      end else begin
        check({name, "_sez"}, 32'(SEZ), 32'(exp_sez));
        check({name, "_se"},  32'(SE),  32'(exp_se));
      end
      if (inject && cyc == 2) start_trig = 1'b0;
      if (inject && cyc == 3) begin
        start_trig = 1'b1;
        random_ops();
      end
      if (cyc == 17) start_trig = 1'b0;
    end
    prev_sez = exp_sez;
    prev_se  = exp_se;
  endtask

  initial begin
    reset      = 1'b0;
    start_trig = 1'b0;
    random_ops();

    // Reset held with start_trig toggling: outputs must stay zero.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("reset_sez", 32'(SEZ), 32'd0);
        check("reset_se",  32'(SE),  32'd0);
      end
      start_trig = ~start_trig;
      random_ops();
    end
    @(negedge clk);
    start_trig = 1'b0;
    reset      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_sez", 32'(SEZ), 32'd0);
      check("post_reset_se",  32'(SE),  32'd0);
    end

    clear_ops();
    run_vec("all_zero", 1'b0);

    clear_ops();
    coef[6] = 16'h4000; samp[6] = 11'h2A0;
    run_vec("pole_only", 1'b0);

    clear_ops();
    coef[0] = 16'h4000; samp[0] = 11'h2A0;
    run_vec("zero_only", 1'b1);

    clear_ops();
    coef[6] = 16'hC000; samp[6] = 11'h2A0;
    run_vec("negative", 1'b0);

    // Back-to-back pole then zero vectors, spurious rise on the second.
    clear_ops();
    coef[6] = 16'h4000; samp[6] = 11'h2A0;
    run_vec("b2b_pole", 1'b0);
    clear_ops();
    coef[0] = 16'h4000; samp[0] = 11'h2A0;
    run_vec("b2b_zero", 1'b1);

    // Extremes: largest exponents (WEXP above 26) and most negative coefficient.
    for (int k = 0; k < 8; k++) begin
      coef[k] = 16'h7FFF;
      samp[k] = 11'h3FF;
    end
    run_vec("max_pos", 1'b0);
    for (int k = 0; k < 8; k++) begin
      coef[k] = 16'h8000;
      samp[k] = 11'h7FF;
    end
    run_vec("min_neg", 1'b0);
    for (int k = 0; k < 8; k++) begin
      coef[k] = 16'h8004;
      samp[k] = 11'h5FF;
    end
    run_vec("near_min", 1'b0);

    for (int v = 0; v < 20; v++) begin
      random_ops();
      run_vec("random", v[0]);
    end

    // Mid-computation reset abort: outputs clear, no result appears afterwards.
    clear_ops();
    coef[6] = 16'h4000; samp[6] = 11'h2A0;
    run_vec("pre_abort", 1'b0);
    random_ops();
    start_trig = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    reset      = 1'b0;
    start_trig = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_sez", 32'(SEZ), 32'd0);
      check("abort_se",  32'(SE),  32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("after_abort_sez", 32'(SEZ), 32'd0);
      check("after_abort_se",  32'(SE),  32'd0);
    end
    prev_sez = 0;
    prev_se  = 0;

    random_ops();
    run_vec("recover", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fmult_accum.md
Name: fmult_accum

Overview:
- Signal-estimate block of the ADPCM (G.726-style) adaptive predictor.
- Each of 8 predictor coefficients (A1,A2 pole; B1..B6 zero) is multiplied by its floating-point history sample (SR1,SR2; DQ1..DQ6) using the FMULT algorithm.
- Products are accumulated to form the zero-section estimate SEZ and the full signal estimate SE.
- One computation runs per rising edge of start_trig, using a shared sequential multiplier clocked by clk.

Parameters:
- None. All widths are fixed.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start_trig  in  1  sample strobe; each rising edge starts one computation. Period is at least 17 clk.
- A1, A2  in  16  pole coefficients, two's complement.
- B1..B6  in  16 each  zero coefficients, two's complement.
- SR1, SR2  in  11 each  reconstructed signal, float format: [10] sign, [9:6] exponent, [5:0] mantissa.
- DQ1..DQ6  in  11 each  quantized difference, same float format.
- SEZ  out  15  zero-section estimate, two's complement.
- SE  out  15  signal estimate, two's complement.
- test_mode, scan_enable  in  1 each  DFT controls; no functional effect.
- scan_in0..scan_in4  in  1 each  scan chain inputs; no functional effect.
- scan_out0..scan_out4  out  1 each  scan chain outputs; RTL drives 0, connected by scan insertion.

Behaviour:
- Reset (reset=0 at clk edge):
  - SEZ=0, SE=0.
  - FSM to IDLE, accumulators cleared, start_trig edge-detect history cleared.
- start_trig synchronisation:
  - start_trig passes through a 2-flop synchroniser, then a rising-edge detector.
  - The detect pulse in IDLE captures all 16 operand inputs into registers.
  - FSM moves to MAC with index k=0 and accumulator cleared.
- MAC state:
  - One product per clk, in order k=0..7: B1*DQ1 .. B6*DQ6, then A1*SR1, A2*SR2.
  - 16-bit accumulator, modulo 2^16.
  - After the k=5 product, the accumulator value is latched as SEZI.
  - After k=7, the full sum is SEI.
- DONE state:
  - SEZ <= SEZI[15:1] and SE <= SEI[15:1] (arithmetic shift right by 1, 15-bit result).
  - FSM returns to IDLE.
- Timing:
  - Outputs update at most 12 clk after start_trig rises.
  - Outputs hold stable until the next update.
  - A start_trig rising edge while not in IDLE is ignored.
- FMULT(C 16b, F 11b) -> W 16b:
  - CS=C[15].
  - CMAG = CS ? (16384 − C>>2) & 8191 : C>>2 (13b, logical shift).
  - CEXP = index of MSB one of CMAG, plus 1; 0 if CMAG=0 (range 0..13).
  - CMANT = CMAG==0 ? 32 : (CMAG<<6)>>CEXP (6b).
  - WS = F[10] ^ CS.
  - WEXP = F[9:6] + CEXP (5b).
  - WMANT = (F[5:0]*CMANT + 48)>>4 (8b).
  - WMAG = WEXP>26 ? ((WMANT<<7)<<(WEXP−26)) & 32767 : (WMANT<<7)>>(26−WEXP).
  - W = WS ? (65536 − WMAG) & 65535 : WMAG.
- Reset asserted mid-computation aborts it; outputs go to 0.
- Outputs are registered; no combinational path from inputs to SEZ/SE.

Test Plan:
- Reset: hold reset=0 for 4 clk, any inputs -> SEZ=0, SE=0; no update while reset is low, even with start_trig toggling.
- All zero: all coefficients and samples 0, start_trig pulse -> SEZ=0x0000, SE=0x0000. Each product is 0 since WMANT=3 and WEXP=0.
- Pole only: A1=0x4000, SR1=0x2A0, all else 0 -> WA1=1072, so SEZ=0x0000, SE=0x0218 (536).
- Zero only: B1=0x4000, DQ1=0x2A0, all else 0 -> SEZ=0x0218, SE=0x0218.
- Negative: A1=0xC000, SR1=0x2A0, all else 0 -> WA1=0xFBD0, so SEZ=0x0000, SE=0x7DE8.
- Back-to-back and ignore: consecutive start_trig periods (17-clk half period) with pole vector then zero vector -> outputs switch to the new values within 12 clk of each rise. An extra start_trig rise injected 3 clk after a start does not alter the result.
